// File: rtl/intdiv_otf_conv_if.sv
`default_nettype none
// ============================================================================
// Module   : intdiv_otf_conv_if
// Purpose  : Handshake bundle for the SD2 -> two's-complement on-the-fly
//            converter. It carries the digit input stream, the word output
//            and the synchronous abort.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   in_abort  : synchronous clear of the converter (driven by master)
//   in_valid  : in_digit valid                     (driven by master)
//   in_ready  : converter accepts a digit          (driven by slave)
//   in_digit  : SD2 digit 11=-1 00=0 01/10=+1      (driven by master)
//   out_valid : out_q holds a completed word       (driven by slave)
//   out_ready : consumer takes out_q               (driven by master)
//   out_q     : N+1-bit two's-complement result    (driven by slave)
//   out_sign  : SD2 sign of the word, only when INTDIV_OTF_SIGN_EN is defined
// Modports : master = digit producer / word consumer side, slave = converter
// ============================================================================
interface intdiv_otf_conv_if #(
  parameter int N = 4
);
  logic         in_abort;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_digit;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_q;
`ifdef INTDIV_OTF_SIGN_EN
  logic [1:0]   out_sign;
`endif

  modport master (
    output in_abort,
    output in_valid,
    input  in_ready,
    output in_digit,
    input  out_valid,
    output out_ready,
`ifdef INTDIV_OTF_SIGN_EN
    input  out_sign,
`endif
    input  out_q
  );

  modport slave (
    input  in_abort,
    input  in_valid,
    output in_ready,
    input  in_digit,
    output out_valid,
    input  out_ready,
`ifdef INTDIV_OTF_SIGN_EN
    output out_sign,
`endif
    output out_q
  );
endinterface
`default_nettype wire

// File: rtl/intdiv_otf_conv.sv
`default_nettype none
// ============================================================================
// Module   : intdiv_otf_conv
// Purpose  : Digit-serial, MSB-first SD2 -> two's-complement converter using
//            on-the-fly conversion. A Q/QM register pair (QM == Q-1) lets a
//            negative digit be absorbed by selecting QM instead of borrowing,
//            so no carry-propagate adder is needed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N      : digits per word (N >= 2); result width N+1
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : intdiv_otf_conv_if.slave (digit stream in, word out, abort)
// Optional feature macro:
//   INTDIV_OTF_SIGN_EN : adds bus.out_sign and the early sign register
// ============================================================================
module intdiv_otf_conv #(
  parameter int N = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  intdiv_otf_conv_if.slave      bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    q;
  logic [N:0]    qm;
  logic [N:0]    out_q_r;
  logic          in_ready_r;
  logic          out_valid_r;
`ifdef INTDIV_OTF_SIGN_EN
  logic [1:0]    sign_r;
`endif

  logic          accept;
  logic          d_neg;
  logic          d_zero;
  logic [N:0]    q_next;
  logic [N:0]    qm_next;

  assign accept = bus.in_valid && in_ready_r;

  // Codes 01 and 10 both mean +1; only 11 is negative.
  assign d_neg  = (bus.in_digit == 2'b11);
  assign d_zero = (bus.in_digit == 2'b00);

  // On-the-fly update; the MSB shifted out is discarded.
  always_comb begin
    q_next  = {q[N-1:0], 1'b1};
    qm_next = {q[N-1:0], 1'b0};
    if (d_zero) begin
      q_next  = {q[N-1:0], 1'b0};
      qm_next = {qm[N-1:0], 1'b1};
    end else if (d_neg) begin
      q_next  = {qm[N-1:0], 1'b1};
      qm_next = {qm[N-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACC;
      cnt         <= '0;
      q           <= '0;
      qm          <= '1;
      out_q_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef INTDIV_OTF_SIGN_EN
      sign_r      <= 2'b00;
`endif
    end else if (bus.in_abort) begin
      // Abort overrides any simultaneous accept or output handshake.
      state       <= ACC;
      cnt         <= '0;
      q           <= '0;
      qm          <= '1;
      out_q_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef INTDIV_OTF_SIGN_EN
      sign_r      <= 2'b00;
`endif
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            q  <= q_next;
            qm <= qm_next;
`ifdef INTDIV_OTF_SIGN_EN
            // The first nonzero digit dominates the remaining tail, so it
            // fixes the sign of the whole word.
            if (sign_r == 2'b00 && !d_zero) begin
              sign_r <= d_neg ? 2'b11 : 2'b01;
            end
`endif
            if (cnt == LAST_CNT) begin
              state       <= DONE;
              cnt         <= '0;
              out_q_r     <= q_next;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= ACC;
            cnt         <= '0;
            q           <= '0;
            qm          <= '1;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef INTDIV_OTF_SIGN_EN
            sign_r      <= 2'b00;
`endif
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
`ifdef INTDIV_OTF_SIGN_EN
  assign bus.out_sign  = sign_r;
`endif

endmodule
`default_nettype wire
